startup_seq: RTL and testbench

STARTUP_SEQ -- requirements
Module: startup_seq

---
 rtl/startup_seq_pkg.sv | 15 +
 rtl/sync_bit.sv | 23 ++
 rtl/startup_seq.sv | 213 +++++++++++++++++++++
 tb/tb_startup_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/startup_seq_pkg.sv
// Shared types for the startup release sequencer: FSM state encoding and debug STATE width.
package startup_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StWaitEos  = 3'd0,
    StGtsRel   = 3'd1,
    StChRel    = 3'd2,
    StRun      = 3'd3,
    StShutdown = 3'd4,
    StAck      = 3'd5
  } state_e;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level input.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/startup_seq.sv
// Startup release sequencer: releases GTS then per-channel user resets after EOS.
// Optional PREQ shutdown/acknowledge handshake is built when STARTUP_SEQ_PREQ_EN is defined.
module startup_seq
  import startup_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned STAGGER_CYC = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EOS,
  input  logic               PREQ,
  input  logic               HOLD,
  output logic               GTS,
  output logic               USRDONEO,
  output logic               USRDONETS,
  output logic [NUM_CH-1:0]  CH_RST,
  output logic               PACK,
  output logic               READY,
  output logic [STATE_W-1:0] STATE
);

  localparam int unsigned CNT_W = $clog2(STAGGER_CYC + 1);
  localparam int unsigned IDX_W = $clog2(NUM_CH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_ALL  = IDX_W'(NUM_CH);
  localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);
  localparam logic [NUM_CH-1:0] CH_TOP   = CH_ONE << (NUM_CH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               gts_q, gts_d;
  logic               doneo_q, doneo_d;
  logic               donets_q, donets_d;
  logic [NUM_CH-1:0]  ch_rst_q, ch_rst_d;
  logic               ready_q, ready_d;
  logic               eos_s;
  logic               step_done;
  logic               go_idle;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_eos (
    .clk (CLK),
    .rst (RST),
    .d   (EOS),
    .q   (eos_s)
  );

`ifdef STARTUP_SEQ_PREQ_EN
  logic preq_s;
  logic pack_q, pack_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_preq (
    .clk (CLK),
    .rst (RST),
    .d   (PREQ),
    .q   (preq_s)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pack_q <= 1'b0;
    end else begin
      pack_q <= pack_d;
    end
  end

  assign PACK = pack_q;
`else
  logic unused_preq;
  assign unused_preq = PREQ;
  assign PACK        = 1'b0;
`endif

  assign step_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    gts_d    = gts_q;
    doneo_d  = doneo_q;
    donets_d = donets_q;
    ch_rst_d = ch_rst_q;
    ready_d  = ready_q;
    go_idle  = 1'b0;
`ifdef STARTUP_SEQ_PREQ_EN
    // PACK is only ever raised in StAck; it drops whenever the request goes away.
    pack_d   = pack_q & preq_s;
`endif
    case (state_q)
      StWaitEos: begin
        if (eos_s && !HOLD) begin
          state_d = StGtsRel;
          gts_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StGtsRel: begin
        if (!HOLD) begin
          if (step_done) begin
            state_d  = StChRel;
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            ch_rst_d = ch_rst_q & ~CH_ONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StChRel: begin
        // idx_q is the next channel to release; IDX_ALL means all are out.
        if (!HOLD) begin
          if (step_done) begin
            cnt_d = '0;
            if (idx_q == IDX_ALL) begin
              state_d  = StRun;
              ready_d  = 1'b1;
              doneo_d  = 1'b1;
              donets_d = 1'b0;
            end else begin
              ch_rst_d = ch_rst_q & ~(CH_ONE << idx_q);
              idx_d    = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRun: begin
`ifdef STARTUP_SEQ_PREQ_EN
        if (preq_s) begin
          state_d  = StShutdown;
          ready_d  = 1'b0;
          doneo_d  = 1'b0;
          donets_d = 1'b1;
          ch_rst_d = ch_rst_q | CH_TOP;
          idx_d    = IDX_W'(NUM_CH - 1);
          cnt_d    = '0;
        end
`endif
      end
`ifdef STARTUP_SEQ_PREQ_EN
      StShutdown: begin
        // idx_q counts channels still released, highest index reasserted first.
        if (step_done) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = StAck;
            gts_d   = 1'b1;
            pack_d  = preq_s;
          end else begin
            ch_rst_d = ch_rst_q | (CH_ONE << (idx_q - 1'b1));
            idx_d    = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck: begin
        pack_d = preq_s;
        if (!preq_s) begin
          go_idle = 1'b1;
        end
      end
`endif
      default: go_idle = 1'b1;
    endcase

    // Loss of EOS outranks HOLD and PREQ; PACK keeps its own handshake.
    if (go_idle || (state_q != StWaitEos && !eos_s)) begin
      state_d  = StWaitEos;
      cnt_d    = '0;
      idx_d    = '0;
      gts_d    = 1'b1;
      doneo_d  = 1'b0;
      donets_d = 1'b1;
      ch_rst_d = '1;
      ready_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StWaitEos;
      cnt_q    <= '0;
      idx_q    <= '0;
      gts_q    <= 1'b1;
      doneo_q  <= 1'b0;
      donets_q <= 1'b1;
      ch_rst_q <= '1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      gts_q    <= gts_d;
      doneo_q  <= doneo_d;
      donets_q <= donets_d;
      ch_rst_q <= ch_rst_d;
      ready_q  <= ready_d;
    end
  end

  assign GTS       = gts_q;
  assign USRDONEO  = doneo_q;
  assign USRDONETS = donets_q;
  assign CH_RST    = ch_rst_q;
  assign READY     = ready_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_startup_seq.sv
// Bench for startup_seq: spec vector table, hand-written corner sequences and a
// randomized run against a progress-based reference model.
module tb_startup_seq;

  localparam int NCH  = 4;
  localparam int S    = 3;
  localparam int SYNC = 2;
`ifdef STARTUP_SEQ_PREQ_EN
  localparam bit PREQ_EN = 1'b1;
`else
  localparam bit PREQ_EN = 1'b0;
`endif

  // Output vector layout: {GTS, USRDONEO, USRDONETS, CH_RST[3:0], PACK, READY, STATE[2:0]}
  localparam logic [11:0] RESET_VEC = 12'b1_0_1_1111_0_0_000;
  localparam logic [11:0] RUN_VEC   = 12'b0_1_0_0000_0_1_011;

  localparam int M_IDLE = 0, M_REL = 1, M_RUN = 2, M_SHUT = 3, M_ACK = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           EOS = 1'b0;
  logic           PREQ = 1'b0;
  logic           HOLD = 1'b0;
  logic           GTS, USRDONEO, USRDONETS, PACK, READY;
  logic [NCH-1:0] CH_RST;
  logic [2:0]     STATE;
  logic [11:0]    dut_vec;

  int checks   = 0;
  int failures = 0;
  int cur_n    = 0;

  // Reference model: release/shutdown progress in unheld cycles plus input delay lines.
  int            m_mode;
  int            m_p;
  bit            m_pack;
  bit [SYNC-1:0] m_es, m_ps;

  startup_seq #(.NUM_CH(NCH), .STAGGER_CYC(S), .SYNC_STAGES(SYNC)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EOS       (EOS),
    .PREQ      (PREQ),
    .HOLD      (HOLD),
    .GTS       (GTS),
    .USRDONEO  (USRDONEO),
    .USRDONETS (USRDONETS),
    .CH_RST    (CH_RST),
    .PACK      (PACK),
    .READY     (READY),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  assign dut_vec = {GTS, USRDONEO, USRDONETS, CH_RST, PACK, READY, STATE};

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_p    = 0;
    m_pack = 1'b0;
    m_es   = '0;
    m_ps   = '0;
  endfunction

  function automatic void model_step(input bit eos_in, input bit preq_in, input bit hold_in,
                                     input bit rst_in);
    bit eo, po;
    if (rst_in) begin
      model_reset();
      return;
    end
    eo = m_es[SYNC-1];
    po = PREQ_EN && m_ps[SYNC-1];
    m_pack = m_pack && po;
    if (m_mode != M_IDLE && !eo) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (eo && !hold_in) begin m_mode = M_REL; m_p = 0; end
        M_REL: if (!hold_in) begin
          m_p++;
          if (m_p == (NCH + 1) * S) m_mode = M_RUN;
        end
        M_RUN: if (po) begin m_mode = M_SHUT; m_p = 0; end
        M_SHUT: begin
          m_p++;
          if (m_p == NCH * S) begin m_mode = M_ACK; m_pack = po; end
        end
        M_ACK: begin
          m_pack = po;
          if (!po) m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    m_es = {m_es[SYNC-2:0], eos_in};
    m_ps = {m_ps[SYNC-2:0], preq_in};
  endfunction

  function automatic logic [11:0] model_vec();
    logic [NCH-1:0] all1, ch;
    logic [2:0]     st;
    bit             gts, run;
    int             r;
    all1 = '1;
    ch   = all1;
    gts  = 1'b1;
    run  = 1'b0;
    st   = 3'd0;
    case (m_mode)
      M_REL: begin
        gts = 1'b0;
        r   = m_p / S;
        if (r > NCH) r = NCH;
        ch  = all1 << r;
        st  = (m_p < S) ? 3'd1 : 3'd2;
      end
      M_RUN: begin gts = 1'b0; ch = '0; run = 1'b1; st = 3'd3; end
      M_SHUT: begin
        gts = 1'b0;
        r   = m_p / S + 1;
        if (r > NCH) r = NCH;
        ch  = all1 << (NCH - r);
        st  = 3'd4;
      end
      M_ACK: st = 3'd5;
      default: ;
    endcase
    return {gts, run, !run, ch, m_pack, run, st};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step(EOS, PREQ, HOLD, RST);
    @(posedge CLK);
    #1;
    check("model", dut_vec, model_vec());
  endtask

  task automatic do_reset();
    EOS  = 1'b0;
    PREQ = 1'b0;
    HOLD = 1'b0;
    RST  = 1'b1;
    model_reset();
    #1;
    check("async_reset", dut_vec, RESET_VEC);
    cycle();
    cycle();
    RST = 1'b0;
  endtask

  typedef struct {
    bit         restart;
    int         n;
    bit         hold;
    bit         gts;
    logic [3:0] ch;
    bit         ready;
    logic [2:0] st;
  } vec_t;

  vec_t        tab[18];
  logic [11:0] exp_v;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Nominal release, then the same with HOLD over edges 7..10.
    tab[0]  = '{1'b1,  2, 1'b0, 1'b1, 4'b1111, 1'b0, 3'd0};
    tab[1]  = '{1'b0,  3, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd1};
    tab[2]  = '{1'b0,  5, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd1};
    tab[3]  = '{1'b0,  6, 1'b0, 1'b0, 4'b1110, 1'b0, 3'd2};
    tab[4]  = '{1'b0,  8, 1'b0, 1'b0, 4'b1110, 1'b0, 3'd2};
    tab[5]  = '{1'b0,  9, 1'b0, 1'b0, 4'b1100, 1'b0, 3'd2};
    tab[6]  = '{1'b0, 12, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd2};
    tab[7]  = '{1'b0, 15, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2};
    tab[8]  = '{1'b0, 17, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2};
    tab[9]  = '{1'b0, 18, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd3};
    tab[10] = '{1'b1,  6, 1'b0, 1'b0, 4'b1110, 1'b0, 3'd2};
    tab[11] = '{1'b0, 10, 1'b1, 1'b0, 4'b1110, 1'b0, 3'd2};
    tab[12] = '{1'b0, 12, 1'b0, 1'b0, 4'b1110, 1'b0, 3'd2};
    tab[13] = '{1'b0, 13, 1'b0, 1'b0, 4'b1100, 1'b0, 3'd2};
    tab[14] = '{1'b0, 16, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd2};
    tab[15] = '{1'b0, 19, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2};
    tab[16] = '{1'b0, 21, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2};
    tab[17] = '{1'b0, 22, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd3};

    #2;
    for (int i = 0; i < 18; i++) begin
      if (tab[i].restart) begin
        do_reset();
        EOS   = 1'b1;
        cur_n = 0;
      end
      HOLD = tab[i].hold;
      while (cur_n < tab[i].n) begin
        cycle();
        cur_n++;
      end
      exp_v = {tab[i].gts, tab[i].ready, !tab[i].ready, tab[i].ch, 1'b0, tab[i].ready, tab[i].st};
      check($sformatf("vec%0d_n%0d", i, tab[i].n), dut_vec, exp_v);
    end
    HOLD = 1'b0;

`ifdef STARTUP_SEQ_PREQ_EN
    // Shutdown handshake from RUN; each step is S cycles apart.
    PREQ = 1'b1;
    repeat (3) cycle();
    check("shut_ch3", dut_vec, 12'b0_0_1_1000_0_0_100);
    repeat (S) cycle();
    check("shut_ch2", dut_vec, 12'b0_0_1_1100_0_0_100);
    repeat (S) cycle();
    check("shut_ch1", dut_vec, 12'b0_0_1_1110_0_0_100);
    repeat (S) cycle();
    check("shut_ch0", dut_vec, 12'b0_0_1_1111_0_0_100);
    repeat (S) cycle();
    check("ack_entry", dut_vec, 12'b1_0_1_1111_1_0_101);
    PREQ = 1'b0;
    repeat (3) cycle();
    check("pack_clear", dut_vec, RESET_VEC);
    cycle();
    check("rerelease_gts", dut_vec, 12'b0_0_1_1111_0_0_001);
    repeat ((NCH + 1) * S) cycle();
    check("rerelease_run", dut_vec, RUN_VEC);
`else
    PREQ = 1'b1;
    repeat (4) cycle();
    PREQ = 1'b0;
    repeat (8) cycle();
    check("preq_ignored", dut_vec, RUN_VEC);
`endif

    // EOS loss in RUN: two synchronizer edges plus the FSM edge.
    EOS = 1'b0;
    repeat (3) cycle();
    check("eos_drop", dut_vec, RESET_VEC);

    // Asynchronous reset mid-release.
    do_reset();
    EOS = 1'b1;
    repeat (10) cycle();
    check("pre_rst_n10", dut_vec, 12'b0_0_1_1100_0_0_010);
    RST = 1'b1;
    model_reset();
    #1;
    check("async_rst_mid", dut_vec, RESET_VEC);
    #2;
    RST = 1'b0;
    repeat (2) cycle();
    check("rst_gts_held", dut_vec, RESET_VEC);
    cycle();
    check("rst_gts_fall", dut_vec, 12'b0_0_1_1111_0_0_001);

    for (int k = 0; k < 4000; k++) begin
      if (RST) begin
        if ($urandom_range(0, 1) == 0) RST = 1'b0;
      end else if ($urandom_range(0, 699) == 0) begin
        RST = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) EOS = ~EOS;
      HOLD = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) PREQ = ~PREQ;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
